// File: rtl/ring_rr_arbiter.sv
// ring_rr_arbiter: round-robin arbiter for N requesters with a one-hot
// priority token. Each grant is held until done, until the owner drops its
// request, or until the hold limit expires. After a release the token moves
// to the position just past the owner, so every requester gets a turn.
module ring_rr_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  parameter int ID_W     = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req,
  input  logic            done,
  output logic [N-1:0]    gnt,
  output logic            gnt_valid,
  output logic [ID_W-1:0] gnt_id,
  output logic [N-1:0]    ptr,
  output logic            timeout
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  // The hold counter only has to reach MAX_HOLD-1. It saturates at all-ones,
  // so it never wraps back past the limit.
  localparam int HC_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HC_W-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HC_W'(MAX_HOLD - 1) : '0;
  localparam bit LIMIT_EN = (MAX_HOLD > 0);

  logic [0:0]      state_reg, state_next;
  logic [N-1:0]    gnt_reg, gnt_next;
  logic [ID_W-1:0] gnt_id_reg, gnt_id_next;
  logic [N-1:0]    ptr_reg, ptr_next;
  logic [HC_W-1:0] hold_reg, hold_next;
  logic            timeout_reg, timeout_next;

  // Winner search. Requests at or above the token position take precedence.
  // If there are none, the lowest request overall wins, which is the wrap
  // from N-1 back to 0.
  logic [N-1:0]    hi_mask;
  logic [N-1:0]    req_hi;
  logic [N-1:0]    req_sel;
  logic [N-1:0]    win_oh;
  logic [ID_W-1:0] win_idx;
  logic [ID_W-1:0] idx_terms [N];
  logic [N-1:0]    ptr_rot;

  assign hi_mask = ~(ptr_reg - N'(1));
  assign req_hi  = req & hi_mask;
  assign req_sel = (|req_hi) ? req_hi : req;
  assign win_oh  = req_sel & (~req_sel + N'(1));

  // Per-bit contributions to the binary index of the winner. The next token
  // position is the current grant rotated up by one place.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_bits
      assign idx_terms[gi] = win_oh[gi] ? ID_W'(gi) : '0;
      assign ptr_rot[gi]   = gnt_reg[(gi + N - 1) % N];
    end
  endgenerate

  // OR-reduce the per-bit terms into the winner index; win_oh is one-hot.
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < N; i++) begin
      win_idx = win_idx | idx_terms[i];
    end
  end

  // Release causes. A timeout is reported only when the hold limit is the
  // sole reason for the release.
  logic owner_req;
  logic limit_hit;
  logic release_any;

  assign owner_req   = req[gnt_id_reg];
  assign limit_hit   = LIMIT_EN && (hold_reg == HOLD_LAST);
  assign release_any = done || !owner_req || limit_hit;

  // Next-state logic for the IDLE/GRANT controller.
  always_comb begin
    state_next   = state_reg;
    gnt_next     = gnt_reg;
    gnt_id_next  = gnt_id_reg;
    ptr_next     = ptr_reg;
    hold_next    = hold_reg;
    timeout_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (|req) begin
          gnt_next    = win_oh;
          gnt_id_next = win_idx;
          hold_next   = '0;
          state_next  = GRANT;
        end
      end
      GRANT: begin
        if (hold_reg != '1) begin
          hold_next = hold_reg + 1'b1;
        end
        if (release_any) begin
          gnt_next     = '0;
          ptr_next     = ptr_rot;
          state_next   = IDLE;
          timeout_next = limit_hit && !done && owner_req;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State registers. Reset clears the grant immediately and sets the token
  // back to requester 0; it does not perform release processing.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg   <= IDLE;
      gnt_reg     <= '0;
      gnt_id_reg  <= '0;
      ptr_reg     <= N'(1);
      hold_reg    <= '0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      gnt_reg     <= gnt_next;
      gnt_id_reg  <= gnt_id_next;
      ptr_reg     <= ptr_next;
      hold_reg    <= hold_next;
      timeout_reg <= timeout_next;
    end
  end

  assign gnt       = gnt_reg;
  assign gnt_valid = |gnt_reg;
  assign gnt_id    = gnt_id_reg;
  assign ptr       = ptr_reg;
  assign timeout   = timeout_reg;

`ifndef SYNTHESIS
  // Structural invariants of the token and grant vectors.
  a_ptr_onehot : assert property (@(posedge clk) disable iff (!reset) $onehot(ptr_reg));
  a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!reset) $onehot0(gnt_reg));
  a_id_match : assert property (@(posedge clk) disable iff (!reset)
                                (|gnt_reg) |-> gnt_reg[gnt_id_reg]);
`endif

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// tb_ring_rr_arbiter: directed scenarios for ring_rr_arbiter (N=4, MAX_HOLD=8).
// The stimulus queues the expected outcome of every grant before it drives
// that grant. A monitor process removes one entry from the queue each time
// a grant ends and compares it against what the DUT did.
module tb_ring_rr_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req;
  logic         done;
  logic [N-1:0] gnt;
  logic         gnt_valid;
  logic [1:0]   gnt_id;
  logic [N-1:0] ptr;
  logic         timeout;

  ring_rr_arbiter #(.N(N), .MAX_HOLD(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id),
    .ptr       (ptr),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [N-1:0] gnt;
    int           len;
    logic [N-1:0] ptr_after;
    logic         to;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs === expv) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Monitor: measures each grant and scores it when gnt_valid falls.
  logic         prev_valid = 1'b0;
  logic [N-1:0] cur_gnt    = '0;
  int           run_len    = 0;
  logic [1:0]   cur_id     = '0;

  always @(negedge clk) begin
    exp_t e;
    if (gnt_valid && !prev_valid) begin
      cur_gnt = gnt;
      cur_id  = gnt_id;
      run_len = 1;
    end else if (gnt_valid) begin
      run_len++;
    end else if (prev_valid) begin
      $display("grant gnt=%b id=%0d len=%0d ptr_after=%b timeout=%b",
               cur_gnt, cur_id, run_len, ptr, timeout);
      if (exp_q.size() == 0) begin
        check("unexpected_grant", 32'(cur_gnt), 32'(0));
      end else begin
        e = exp_q.pop_front();
        check("grant_vec", 32'(cur_gnt), 32'(e.gnt));
        check("grant_len", 32'(run_len), 32'(e.len));
        check("ptr_after", 32'(ptr), 32'(e.ptr_after));
        check("timeout", 32'(timeout), 32'(e.to));
      end
    end
    if (timeout && !(prev_valid && !gnt_valid)) begin
      check("stray_timeout", 32'(timeout), 32'(0));
    end
    prev_valid = gnt_valid;
  end

  function automatic exp_t mk(input logic [N-1:0] g, input int l,
                              input logic [N-1:0] p, input logic t);
    exp_t e;
    e.gnt = g; e.len = l; e.ptr_after = p; e.to = t;
    return e;
  endfunction

  // Returns at the first negedge that shows gnt_valid high (bounded).
  task automatic wait_grant();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (gnt_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check("grant_wait_expired", 32'(0), 32'(1));
  endtask

  // Returns at the first negedge that shows gnt_valid low (bounded).
  task automatic wait_release();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!gnt_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check("release_wait_expired", 32'(0), 32'(1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    req   = 4'b1111;
    done  = 1'b0;

    // Reset is held for two edges while every requester asks.
    repeat (2) @(negedge clk);
    check("reset_gnt", 32'(gnt), 32'(0));
    check("reset_valid", 32'(gnt_valid), 32'(0));
    check("reset_id", 32'(gnt_id), 32'(0));
    check("reset_ptr", 32'(ptr), 32'(4'b0001));
    check("reset_timeout", 32'(timeout), 32'(0));

    // Rotation: the grant order is 0,1,2,3,0 with done two cycles into each grant.
    exp_q.push_back(mk(4'b0001, 2, 4'b0010, 1'b0));
    exp_q.push_back(mk(4'b0010, 2, 4'b0100, 1'b0));
    exp_q.push_back(mk(4'b0100, 2, 4'b1000, 1'b0));
    exp_q.push_back(mk(4'b1000, 2, 4'b0001, 1'b0));
    exp_q.push_back(mk(4'b0001, 2, 4'b0010, 1'b0));
    reset = 1'b1;
    @(negedge clk);
    check("reset_release_gnt", 32'(gnt), 32'(4'b0001));
    for (int k = 0; k < 5; k++) begin
      wait_grant();
      @(negedge clk);
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
      check("idle_gap", 32'(gnt_valid), 32'(0));
      if (k == 4) req = 4'b0000;
    end

    // Move the token to 2, then check that the search wraps past empty slots 2 and 3.
    exp_q.push_back(mk(4'b0010, 1, 4'b0100, 1'b0));
    req = 4'b0010;
    wait_grant();
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    req  = 4'b0000;
    check("ptr_before_wrap", 32'(ptr), 32'(4'b0100));

    exp_q.push_back(mk(4'b0001, 3, 4'b0010, 1'b0));
    req = 4'b0011;
    wait_grant();
    repeat (2) @(negedge clk);
    req = 4'b0000;               // the owner drops its request
    @(negedge clk);

    // Timeout: requester 1 holds its request and never sends done.
    exp_q.push_back(mk(4'b0010, 8, 4'b0100, 1'b1));
    req = 4'b0010;
    wait_grant();
    wait_release();
    // The next grant is released by done on the same edge as the hold limit.
    exp_q.push_back(mk(4'b0010, 8, 4'b0100, 1'b0));
    @(negedge clk);
    check("regrant_after_gap", 32'(gnt), 32'(4'b0010));
    repeat (7) @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    req  = 4'b0000;

    // Reset in the middle of a grant to requester 3, when hold_cnt is 3.
    exp_q.push_back(mk(4'b1000, 4, 4'b0001, 1'b0));
    req = 4'b1000;
    wait_grant();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midreset_gnt", 32'(gnt), 32'(0));
    check("midreset_ptr", 32'(ptr), 32'(4'b0001));
    check("midreset_timeout", 32'(timeout), 32'(0));
    exp_q.push_back(mk(4'b1000, 1, 4'b0001, 1'b0));
    reset = 1'b1;
    @(negedge clk);
    check("post_reset_regrant", 32'(gnt), 32'(4'b1000));
    check("post_reset_id", 32'(gnt_id), 32'(3));
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    req  = 4'b0000;
    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
